sd_operand_tx: RTL and testbench

- Transmitter end of the signed-digit operand interface: accepts three parallel two's-complement fractions (x, y, z) over a valid/ready handshake and streams them MSD-first as radix-2 signed digits (rbr_pkg::signed_digit), one digit per operand per cycle, plus an advance strobe.
- Sits directly in front of the online sum-of-squares datapath and other online operators that consume x/y/z digit streams with an en strobe.
- Double-buffered, so consecutive operand sets stream back-to-back with no bubble.

---
 rtl/sd_operand_tx.sv | 203 ++++++++++++++++++++
 tb/tb_sd_operand_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_operand_tx.sv
// Radix-2 signed-digit type shared by the online operators.
package rbr_pkg;

  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;

endpackage

// sd_operand_tx: takes x/y/z two's-complement fractions over a valid/ready
// handshake and streams them most-significant digit first as radix-2 signed
// digits, one digit per operand per advance. Each set is followed by
// FLUSH_CYCLES zero digits. A pending buffer lets the next set follow the
// current one with no idle cycle. WIDTH must be at least 2.
module sd_operand_tx
  import rbr_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter int RECODE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  input  logic             out_ready,
  output logic             en,
  output signed_digit      x,
  output signed_digit      y,
  output signed_digit      z,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] LAST_DATA  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + FLUSH_CYCLES - 1);
  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Active operands are shift registers: the MSB is always the current bit
  // b_i and the bit below it is b_{i+1}; zeros shift in, so b_WIDTH = 0.
  logic [WIDTH-1:0] act_x, act_y, act_z;
  logic [WIDTH-1:0] pend_x, pend_y, pend_z;
  logic             pend_full;

  logic accept, adv;
  logic load_in, load_pend, fill_pend, shift_act, frame_end;

  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;
  assign adv      = (state != IDLE) && out_ready;
  assign en       = adv;
  assign busy     = (state != IDLE);

  // Maps the current bit (and the next one for Booth) to a signed digit.
  function automatic signed_digit encode_digit(input logic b_cur,
                                               input logic b_nxt,
                                               input logic first);
    signed_digit d;
    if (RECODE != 0) begin
      d.plus  = b_nxt & ~b_cur;
      d.minus = b_cur & ~b_nxt;
    end else if (first) begin
      d.plus  = 1'b0;
      d.minus = b_cur;
    end else begin
      d.plus  = b_cur;
      d.minus = 1'b0;
    end
    return d;
  endfunction

  // Control state, digit counter and pending-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_full <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_pend) begin
        pend_full <= 1'b0;
      end else if (fill_pend) begin
        pend_full <= 1'b1;
      end
    end
  end

  // Operand storage; contents are only meaningful while the flags say so.
  always_ff @(posedge clk) begin
    if (load_in) begin
      act_x <= in_x;
      act_y <= in_y;
      act_z <= in_z;
    end else if (load_pend) begin
      act_x <= pend_x;
      act_y <= pend_y;
      act_z <= pend_z;
    end else if (shift_act) begin
      act_x <= act_x << 1;
      act_y <= act_y << 1;
      act_z <= act_z << 1;
    end
    if (fill_pend) begin
      pend_x <= in_x;
      pend_y <= in_y;
      pend_z <= in_z;
    end
  end

  // Next state, counter and buffer moves; everything steps only on advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_in   = 1'b0;
    load_pend = 1'b0;
    fill_pend = 1'b0;
    shift_act = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_in   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (adv) begin
          if (cnt == LAST_DATA) begin
            if (HAS_FLUSH) begin
              state_nxt = FLUSH;
              cnt_nxt   = cnt + CW'(1);
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            shift_act = 1'b1;
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          if (cnt == LAST_FLUSH) begin
            frame_end = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (frame_end) begin
      cnt_nxt = '0;
      if (pend_full) begin
        load_pend = 1'b1;
        state_nxt = STREAM;
      end else if (accept) begin
        load_in   = 1'b1;
        state_nxt = STREAM;
      end else begin
        state_nxt = IDLE;
      end
    end
    fill_pend = accept && !load_in;
  end

  // Digit and frame-marker outputs depend only on registered state, so they
  // hold steady while the sink stalls.
  always_comb begin
    x           = '0;
    y           = '0;
    z           = '0;
    frame_start = 1'b0;
    frame_last  = 1'b0;
    if (state == STREAM) begin
      x           = encode_digit(act_x[WIDTH-1], act_x[WIDTH-2], cnt == '0);
      y           = encode_digit(act_y[WIDTH-1], act_y[WIDTH-2], cnt == '0);
      z           = encode_digit(act_z[WIDTH-1], act_z[WIDTH-2], cnt == '0);
      frame_start = (cnt == '0);
      frame_last  = !HAS_FLUSH && (cnt == LAST_DATA);
    end else if (state == FLUSH) begin
      frame_last = (cnt == LAST_FLUSH);
    end
  end

endmodule

// File: tb/tb_sd_operand_tx.sv
`timescale 1ns/1ps
// tb_sd_operand_tx: direct and Booth-recoded transmitters driven with the
// same stimulus and checked each cycle against a frame-level model, plus
// hand-computed digit sequences for a few operand sets.
module tb_sd_operand_tx;
  import rbr_pkg::*;

  localparam int W  = 8;
  localparam int F  = 4;
  localparam int FL = W + F;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] Z = 2'b00;

  typedef logic [1:0] dseq_t [FL];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [W-1:0] in_z = '0;

  logic in_ready0, en0, fs0, fl0, busy0;
  logic in_ready1, en1, fs1, fl1, busy1;
  signed_digit x0, y0, z0, x1, y1, z1;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  bit rand_ready = 1'b0;
  int en_count = 0;
  int fl_count = 0;

  // Model: operand sets held by the transmitter, oldest (streaming) first,
  // and the digit position reached in that oldest set.
  logic [3*W-1:0] mq[$];
  int mpos = 0;
  int sum_x[2], sum_y[2], sum_z[2];
  dseq_t lx0, lx1, ly0, ly1, lz0, lz1;

  always #5 clk = ~clk;

  sd_operand_tx #(.WIDTH(W), .FLUSH_CYCLES(F), .RECODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_ready(out_ready),
    .en(en0), .x(x0), .y(y0), .z(z0),
    .frame_start(fs0), .frame_last(fl0), .busy(busy0)
  );

  sd_operand_tx #(.WIDTH(W), .FLUSH_CYCLES(F), .RECODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_ready(out_ready),
    .en(en1), .x(x1), .y(y1), .z(z1),
    .frame_start(fs1), .frame_last(fl1), .busy(busy1)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // b_i of a fraction b0.b1..b(W-1); positions past the end read as 0.
  function automatic int bit_of(input logic [W-1:0] v, input int i);
    if (i >= W) return 0;
    return int'(v[W-1-i]);
  endfunction

  function automatic int digit_of(input logic [W-1:0] v, input int i, input int recode);
    if (i >= W) return 0;
    if (recode != 0) return bit_of(v, i + 1) - bit_of(v, i);
    if (i == 0) return -bit_of(v, 0);
    return bit_of(v, i);
  endfunction

  function automatic logic [1:0] enc(input int d);
    if (d > 0) return P;
    if (d < 0) return M;
    return Z;
  endfunction

  function automatic int sd_val(input signed_digit d);
    return int'(d.plus) - int'(d.minus);
  endfunction

  // Model update: a set leaves after its last flush digit advances; a new
  // set is taken whenever fewer than two are held.
  always @(posedge clk) begin
    bit adv;
    bit acc;
    if (rst) begin
      mq.delete();
      mpos = 0;
    end else begin
      adv = out_ready && (mq.size() > 0);
      acc = in_valid && (mq.size() < 2);
      if (adv) begin
        mpos++;
        if (mpos == FL) begin
          mq.delete(0);
          mpos = 0;
        end
      end
      if (acc) mq.push_back({in_x, in_y, in_z});
    end
  end

  task automatic cmp_dut(input int r, input logic ir, input logic e, input logic fs,
                         input logic fl, input logic bz, input signed_digit dx,
                         input signed_digit dy, input signed_digit dz);
    bit act;
    logic [W-1:0] hx, hy, hz;
    act = (mq.size() > 0);
    {hx, hy, hz} = act ? mq[0] : '0;
    checkOutput($sformatf("r%0d.in_ready", r), int'(ir), int'(mq.size() < 2));
    checkOutput($sformatf("r%0d.en", r), int'(e), int'(act && out_ready));
    checkOutput($sformatf("r%0d.busy", r), int'(bz), int'(act));
    checkOutput($sformatf("r%0d.frame_start", r), int'(fs), int'(act && mpos == 0));
    checkOutput($sformatf("r%0d.frame_last", r), int'(fl), int'(act && mpos == FL - 1));
    checkOutput($sformatf("r%0d.x[%0d]", r, mpos), int'(dx),
                act ? int'(enc(digit_of(hx, mpos, r))) : 0);
    checkOutput($sformatf("r%0d.y[%0d]", r, mpos), int'(dy),
                act ? int'(enc(digit_of(hy, mpos, r))) : 0);
    checkOutput($sformatf("r%0d.z[%0d]", r, mpos), int'(dz),
                act ? int'(enc(digit_of(hz, mpos, r))) : 0);
    if (act && out_ready && mpos < W) begin
      if (mpos == 0) begin
        sum_x[r] = 0;
        sum_y[r] = 0;
        sum_z[r] = 0;
      end
      sum_x[r] += sd_val(dx) * (1 << (W - 1 - mpos));
      sum_y[r] += sd_val(dy) * (1 << (W - 1 - mpos));
      sum_z[r] += sd_val(dz) * (1 << (W - 1 - mpos));
      if (mpos == W - 1) begin
        checkOutput($sformatf("r%0d.sum_x", r), sum_x[r], int'($signed(hx)));
        checkOutput($sformatf("r%0d.sum_y", r), sum_y[r], int'($signed(hy)));
        checkOutput($sformatf("r%0d.sum_z", r), sum_z[r], int'($signed(hz)));
      end
    end
  endtask

  // Compare both transmitters against the model every cycle.
  always @(negedge clk) begin
    if (checking) begin
      cmp_dut(0, in_ready0, en0, fs0, fl0, busy0, x0, y0, z0);
      cmp_dut(1, in_ready1, en1, fs1, fl1, busy1, x1, y1, z1);
      if (en0) en_count++;
      if (en0 && fl0) fl_count++;
    end
  end

  // One clock step; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one operand set and hold it until taken. Entered just after an edge.
  task automatic applyStimulus(input logic [W-1:0] vx, input logic [W-1:0] vy,
                               input logic [W-1:0] vz);
    bit done;
    done = 1'b0;
    in_x = vx;
    in_y = vy;
    in_z = vz;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready0;
      tick();
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (mq.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    if (mq.size() != 0) checkOutput("idle_timeout", 0, 1);
  endtask

  // Checks a whole frame against hand-computed digits, starting at digit 0.
  task automatic literal_frame(input string tag);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.x0[%0d]", tag, i), int'(x0), int'(lx0[i]));
      checkOutput($sformatf("%s.x1[%0d]", tag, i), int'(x1), int'(lx1[i]));
      checkOutput($sformatf("%s.y0[%0d]", tag, i), int'(y0), int'(ly0[i]));
      checkOutput($sformatf("%s.y1[%0d]", tag, i), int'(y1), int'(ly1[i]));
      checkOutput($sformatf("%s.z0[%0d]", tag, i), int'(z0), int'(lz0[i]));
      checkOutput($sformatf("%s.z1[%0d]", tag, i), int'(z1), int'(lz1[i]));
      checkOutput($sformatf("%s.fs[%0d]", tag, i), int'(fs0), int'(i == 0));
      checkOutput($sformatf("%s.fl[%0d]", tag, i), int'(fl0), int'(i == FL - 1));
      checkOutput($sformatf("%s.en[%0d]", tag, i), int'(en0), 1);
      tick();
    end
  endtask

  // x=0x60 (0.75), y=0x80 (-1), z=0.
  task automatic set_lit_t1();
    lx0 = '{Z, P, P, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    lx1 = '{P, Z, M, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    ly0 = '{M, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    ly1 = '{M, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    lz0 = '{Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    lz1 = '{Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
  endtask

  initial begin
    int s;
    int f;

    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    @(negedge clk);
    checkOutput("rst.en", int'(en0), 0);
    checkOutput("rst.busy", int'(busy0), 0);
    checkOutput("rst.in_ready", int'(in_ready0), 1);
    checkOutput("rst.x", int'(x0), 0);
    checkOutput("rst.frame_start", int'(fs0), 0);
    checkOutput("rst.frame_last", int'(fl0), 0);
    tick();
    rst = 1'b0;

    $display("[TB] single frame, both encodings");
    set_lit_t1();
    s = en_count;
    applyStimulus(8'h60, 8'h80, 8'h00);
    literal_frame("t1");
    checkOutput("t1.en_count", en_count - s, FL);

    // x=0xFF (-1/128), y=0x01 (1/128), z=0x7F (127/128).
    lx0 = '{M, P, P, P, P, P, P, P, Z, Z, Z, Z};
    lx1 = '{Z, Z, Z, Z, Z, Z, Z, M, Z, Z, Z, Z};
    ly0 = '{Z, Z, Z, Z, Z, Z, Z, P, Z, Z, Z, Z};
    ly1 = '{Z, Z, Z, Z, Z, Z, P, M, Z, Z, Z, Z};
    lz0 = '{Z, P, P, P, P, P, P, P, Z, Z, Z, Z};
    lz1 = '{P, Z, Z, Z, Z, Z, Z, M, Z, Z, Z, Z};
    applyStimulus(8'hFF, 8'h01, 8'h7F);
    literal_frame("t2");

    $display("[TB] back-to-back sets");
    s = en_count;
    f = fl_count;
    applyStimulus(8'h12, 8'h34, 8'h56);
    applyStimulus(8'h9A, 8'hBC, 8'hDE);
    applyStimulus(8'hF0, 8'h0F, 8'hA5);
    wait_idle();
    checkOutput("b2b.en_count", en_count - s, 3 * FL);
    checkOutput("b2b.frames", fl_count - f, 3);

    $display("[TB] sink stall at digit 4");
    s = en_count;
    applyStimulus(8'h5A, 8'h00, 8'h00);
    repeat (4) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall.en", int'(en0), 0);
      checkOutput("stall.x0", int'(x0), int'(P));
      checkOutput("stall.x1", int'(x1), int'(M));
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("resume.x0", int'(x0), int'(Z));
    checkOutput("resume.x1", int'(x1), int'(P));
    wait_idle();
    checkOutput("stall.en_count", en_count - s, FL);

    $display("[TB] reset mid-frame with pending full");
    applyStimulus(8'h33, 8'h44, 8'h55);
    applyStimulus(8'h66, 8'h77, 8'h88);
    repeat (4) tick();
    @(negedge clk);
    checkOutput("mid.in_ready", int'(in_ready0), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort.en", int'(en0), 0);
    checkOutput("abort.busy", int'(busy0), 0);
    checkOutput("abort.in_ready", int'(in_ready0), 1);
    tick();
    set_lit_t1();
    applyStimulus(8'h60, 8'h80, 8'h00);
    literal_frame("t5");

    $display("[TB] random operands with random sink stalls");
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(W'($urandom), W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
